// File: rtl/taxi_pkg.sv
// Shared constants for the Taxi state encoder and decoder: grid sizes, widths and FSM state encoding.
package taxi_pkg;

  localparam int unsigned N_ROWS   = 5;
  localparam int unsigned N_COLS   = 5;
  localparam int unsigned N_PASS   = 5;
  localparam int unsigned N_DEST   = 4;
  localparam int unsigned STATE_W  = 9;
  localparam int unsigned ACC_W    = 10;
  localparam int unsigned N_STATES = 500;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_COL  = 3'd1;
  localparam logic [2:0] S_PASS = 3'd2;
  localparam logic [2:0] S_DEST = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

endpackage

// File: rtl/taxi_encoder_if.sv
// Handshake bundle between the environment step logic (master) and the Taxi encoder (slave).
interface taxi_encoder_if;

  logic                         in_valid;
  logic                         in_ready;
  logic [2:0]                   taxi_row;
  logic [2:0]                   taxi_col;
  logic [2:0]                   pass_idx;
  logic [1:0]                   dest_idx;
  logic                         out_valid;
  logic                         out_ready;
  logic [taxi_pkg::STATE_W-1:0] encoded_state;
  logic                         err;

  modport master (
    output in_valid, taxi_row, taxi_col, pass_idx, dest_idx, out_ready,
    input  in_ready, out_valid, encoded_state, err
  );

  modport slave (
    input  in_valid, taxi_row, taxi_col, pass_idx, dest_idx, out_ready,
    output in_ready, out_valid, encoded_state, err
  );

endinterface

// File: rtl/taxi_horner_step.sv
// One Horner step, acc_next = acc*K + x, with the constant multiply built as a shift-add over K's set bits.
module taxi_horner_step #(
  parameter int unsigned K     = 5,
  parameter int unsigned ACC_W = 10,
  parameter int unsigned X_W   = 3
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [X_W-1:0]   x,
  output logic [ACC_W-1:0] acc_next
);

  localparam logic [3:0] K_BITS = 4'(K);

  logic [ACC_W-1:0] prod_s;

  // Shift-add constant multiply followed by the digit add
  always_comb begin
    prod_s = '0;
    for (int i = 0; i < 4; i++) begin
      if (K_BITS[i]) begin
        prod_s = prod_s + (acc << i);
      end else begin
        prod_s = prod_s;
      end
    end
    acc_next = prod_s + ACC_W'(x);
  end

endmodule

// File: rtl/taxi_encoder.sv
// Taxi state encoder: ((row*5+col)*5+pass)*4+dest via a 4-step Horner FSM with valid/ready on both sides.
// Optional range check on accepted fields is enabled by defining TAXI_ENC_RANGE_CHECK_EN.
module taxi_encoder
  import taxi_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  taxi_encoder_if.slave  bus
);

  logic [2:0]         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [2:0]         col_q, col_d;
  logic [2:0]         pass_q, pass_d;
  logic [1:0]         dest_q, dest_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [STATE_W-1:0] enc_q, enc_d;
  logic               err_out_q, err_out_d;

  logic [ACC_W-1:0]   acc_col_s, acc_pass_s, acc_dest_s;
  logic               range_err_s;
  logic               accept_s;

  taxi_horner_step #(.K(N_COLS), .ACC_W(ACC_W), .X_W(3)) u_step_col (
    .acc(acc_q), .x(col_q), .acc_next(acc_col_s)
  );
  taxi_horner_step #(.K(N_PASS), .ACC_W(ACC_W), .X_W(3)) u_step_pass (
    .acc(acc_q), .x(pass_q), .acc_next(acc_pass_s)
  );
  taxi_horner_step #(.K(N_DEST), .ACC_W(ACC_W), .X_W(2)) u_step_dest (
    .acc(acc_q), .x(dest_q), .acc_next(acc_dest_s)
  );

`ifdef TAXI_ENC_RANGE_CHECK_EN
  assign range_err_s = (bus.taxi_row >= 3'(N_ROWS)) ||
                       (bus.taxi_col >= 3'(N_COLS)) ||
                       (bus.pass_idx >= 3'(N_PASS));
`else
  assign range_err_s = 1'b0;
`endif

  assign accept_s = bus.in_valid & in_ready_q;

  // Next-state, accumulator and output-register logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    col_d       = col_q;
    pass_d      = pass_q;
    dest_d      = dest_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    enc_d       = enc_q;
    err_out_d   = err_out_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d    = S_COL;
          acc_d      = ACC_W'(bus.taxi_row);
          col_d      = bus.taxi_col;
          pass_d     = bus.pass_idx;
          dest_d     = bus.dest_idx;
          err_d      = range_err_s;
          in_ready_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COL: begin
        acc_d   = acc_col_s;
        state_d = S_PASS;
      end
      S_PASS: begin
        acc_d   = acc_pass_s;
        state_d = S_DEST;
      end
      S_DEST: begin
        // Output registers load on the edge entering S_OUT so they are valid with out_valid
        acc_d       = acc_dest_s;
        state_d     = S_OUT;
        out_valid_d = 1'b1;
        enc_d       = err_q ? {STATE_W{1'b0}} : acc_dest_s[STATE_W-1:0];
        err_out_d   = err_q;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d     = S_IDLE;
        acc_d       = {ACC_W{1'b0}};
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      col_q       <= 3'd0;
      pass_q      <= 3'd0;
      dest_q      <= 2'd0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      enc_q       <= {STATE_W{1'b0}};
      err_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      col_q       <= col_d;
      pass_q      <= pass_d;
      dest_q      <= dest_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      enc_q       <= enc_d;
      err_out_q   <= err_out_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.encoded_state = enc_q;
  assign bus.err           = err_out_q;

endmodule

// File: tb/tb_taxi_encoder.sv
// Directed, table-driven bench for taxi_encoder, plus back-pressure and mid-operation reset sequences.
module tb_taxi_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  taxi_encoder_if bus();

  taxi_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] pass;
    logic [1:0] dest;
    logic [8:0] exp_enc;
    logic       exp_err;
    logic       rt;
    string      name;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_fields(input logic [2:0] r, input logic [2:0] c,
                              input logic [2:0] p, input logic [1:0] d);
    bus.taxi_row = r;
    bus.taxi_col = c;
    bus.pass_idx = p;
    bus.dest_idx = d;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int q;
    int rr, cc, pp, dd;
    wait_idle();
    drive_fields(v.row, v.col, v.pass, v.dest);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    drive_fields(3'd6, 3'd1, 3'd6, 2'd2);
    check({v.name, "_in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
    check({v.name, "_valid_e0"}, {31'd0, bus.out_valid}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check({v.name, "_valid_early"}, {31'd0, bus.out_valid}, 32'd0);
    end
    @(negedge clk);
    check({v.name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({v.name, "_enc"}, {23'd0, bus.encoded_state}, {23'd0, v.exp_enc});
    check({v.name, "_err"}, {31'd0, bus.err}, {31'd0, v.exp_err});
    if (v.rt) begin
      q  = int'(bus.encoded_state);
      dd = q % 4;  q = q / 4;
      pp = q % 5;  q = q / 5;
      cc = q % 5;  rr = q / 5;
      check({v.name, "_rt_fields"}, 32'(((rr * 8 + cc) * 8 + pp) * 4 + dd),
            32'(((int'(v.row) * 8 + int'(v.col)) * 8 + int'(v.pass)) * 4 + int'(v.dest)));
    end
    @(negedge clk);
    check({v.name, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    check({v.name, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_fields(3'd0, 3'd0, 3'd0, 2'd0);

    vecs[0] = '{3'd2, 3'd0, 3'd2, 2'd3, 9'd211, 1'b0, 1'b1, "v211"};
    vecs[1] = '{3'd0, 3'd0, 3'd0, 2'd0, 9'd0,   1'b0, 1'b1, "vzero"};
    vecs[2] = '{3'd4, 3'd4, 3'd4, 2'd3, 9'd499, 1'b0, 1'b1, "vmax"};
    vecs[3] = '{3'd1, 3'd3, 3'd4, 2'd0, 9'd176, 1'b0, 1'b1, "v176"};
    vecs[4] = '{3'd3, 3'd2, 3'd1, 2'd2, 9'd346, 1'b0, 1'b1, "v346"};
`ifdef TAXI_ENC_RANGE_CHECK_EN
    vecs[5] = '{3'd5, 3'd0, 3'd0, 2'd0, 9'd0,   1'b1, 1'b0, "row5"};
    vecs[6] = '{3'd7, 3'd7, 3'd7, 2'd3, 9'd0,   1'b1, 1'b0, "all7"};
    vecs[7] = '{3'd0, 3'd5, 3'd0, 2'd0, 9'd0,   1'b1, 1'b0, "col5"};
    vecs[8] = '{3'd0, 3'd0, 3'd5, 2'd1, 9'd0,   1'b1, 1'b0, "pass5"};
`else
    vecs[5] = '{3'd5, 3'd0, 3'd0, 2'd0, 9'd500 - 9'd0, 1'b0, 1'b0, "row5"};
    vecs[6] = '{3'd7, 3'd7, 3'd7, 2'd3, 9'd359, 1'b0, 1'b0, "all7"};
    vecs[7] = '{3'd0, 3'd5, 3'd0, 2'd0, 9'd100, 1'b0, 1'b0, "col5"};
    vecs[8] = '{3'd0, 3'd0, 3'd5, 2'd1, 9'd21,  1'b0, 1'b0, "pass5"};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_enc",       {23'd0, bus.encoded_state}, 32'd0);
    check("rst_err",       {31'd0, bus.err},       32'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // Back-pressure: result held, second input ignored, next input only after handshake
    wait_idle();
    drive_fields(3'd1, 3'd3, 3'd4, 2'd0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_enc",   {23'd0, bus.encoded_state}, 32'd176);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        drive_fields(3'd3, 3'd2, 3'd1, 2'd2);
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_hold_enc",   {23'd0, bus.encoded_state}, 32'd176);
      check("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    drive_fields(3'd0, 3'd4, 3'd0, 2'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.in_ready},  32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_next_accepted", {31'd0, bus.in_ready}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("bp_next_early", {31'd0, bus.out_valid}, 32'd0);
    end
    @(negedge clk);
    check("bp_next_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_next_enc",   {23'd0, bus.encoded_state}, 32'd81);
    @(negedge clk);

    // Asynchronous reset while the FSM is in S_PASS
    wait_idle();
    drive_fields(3'd4, 3'd4, 3'd4, 2'd3);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_enc",       {23'd0, bus.encoded_state}, 32'd0);
    check("arst_err",       {31'd0, bus.err},       32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("arst_no_emit", 32'(seen), 32'd0);
    check("arst_idle_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
